// File: rtl/cpu_core_pkg.sv
// Shared core package: opcodes, BHT counter type, NOP, fetch->decode bundle.
// Also provides B/J immediate extraction helpers and the PC_INIT default.
`ifndef PC_INIT
`define PC_INIT 32'h0000_0000
`endif

package cpu_core_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_cnt_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            pred;
  } if_id_t;

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7],
            i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12],
            i[20], i[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_predictor_if.sv
// Fetch bus: imem address/instruction plus the fetch->decode register.
// master = fetch stage, slave = memory/decode side.
interface fetch_predictor_if;
  import cpu_core_pkg::*;

  logic [XLEN-1:0] imem_addr_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_o;
  logic [31:0]     instr_o;
  logic            pred_taken_o;
  logic            bubble_o;

  modport master (
    output imem_addr_o, pc_o, instr_o,
    output pred_taken_o, bubble_o,
    input  instr_i
  );

  modport slave (
    input  imem_addr_o, pc_o, instr_o,
    input  pred_taken_o, bubble_o,
    output instr_i
  );
endinterface

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating direction counters, reset to WNT.
// Ports: combinational read (rd_idx_i/rd_cnt_o), sync update (upd_*).
module bht_2bit
  import cpu_core_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic [IW-1:0] rd_idx_i,
  output bht_cnt_t      rd_cnt_o,
  input  logic          upd_en_i,
  input  logic [IW-1:0] upd_idx_i,
  input  logic          upd_taken_i
);
  bht_cnt_t cnt_q [ENTRIES];
  bht_cnt_t cnt_d [ENTRIES];
  bht_cnt_t cur;

  // No bypass: a same-cycle update is not visible to the read.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_comb begin
    cnt_d = cnt_q;
    cur   = cnt_q[upd_idx_i];
    if (upd_en_i) begin
      if (upd_taken_i && cur != ST)
        cnt_d[upd_idx_i] = bht_cnt_t'(cur + 2'd1);
      else if (!upd_taken_i && cur != SNT)
        cnt_d[upd_idx_i] = bht_cnt_t'(cur - 2'd1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++)
        cnt_q[i] <= WNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fetch_predictor.sv
// Fetch PC generator with bimodal B-type prediction, JAL always taken.
// Ports: clock/reset/stall, fetch bus (fp), flush redirect, BHT training.
module fetch_predictor
  import cpu_core_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_INIT = `PC_INIT,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            stall_i,
  fetch_predictor_if.master fp,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            res_valid_i,
  input  logic [XLEN-1:0] res_pc_i,
  input  logic            res_taken_i
);
  localparam int IW = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0] pc_q, pc_d;
  if_id_t          dec_q, dec_d;
  logic            bubble_q, bubble_d;

  logic [6:0]      opcode;
  logic            is_br, is_jal;
  logic [31:0]     imm;
  logic [XLEN-1:0] target;
  bht_cnt_t        rd_cnt;
  logic            pred;

  logic unused_bits;
  assign unused_bits = ^{res_pc_i[XLEN-1:IW+2],
                         res_pc_i[1:0]};

  bht_2bit #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .rd_idx_i    (pc_q[IW+1:2]),
    .rd_cnt_o    (rd_cnt),
    .upd_en_i    (res_valid_i && !stall_i),
    .upd_idx_i   (res_pc_i[IW+1:2]),
    .upd_taken_i (res_taken_i)
  );

  assign opcode = fp.instr_i[6:0];
  assign is_br  = (opcode == OP_BRANCH);
  assign is_jal = (opcode == OP_JAL);
  assign imm    = is_jal ? imm_j(fp.instr_i)
                         : imm_b(fp.instr_i);
  // Matches execute's resolution target so its compare is exact.
  assign target = pc_q + 32'd4 + imm;
  assign pred   = is_jal | (is_br & rd_cnt[1]);

  always_comb begin
    pc_d     = pc_q;
    dec_d    = dec_q;
    bubble_d = bubble_q;
    if (flush_i) begin
      pc_d        = redirect_pc_i;
      dec_d.instr = INSTR_NOP;
      dec_d.pred  = 1'b0;
      bubble_d    = 1'b1;
    end else if (!stall_i) begin
      pc_d     = pred ? target : pc_q + 32'd4;
      dec_d    = '{pc: pc_q, instr: fp.instr_i,
                   pred: pred};
      bubble_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q     <= PC_INIT;
      dec_q    <= '{pc: PC_INIT, instr: INSTR_NOP,
                    pred: 1'b0};
      bubble_q <= 1'b1;
    end else begin
      pc_q     <= pc_d;
      dec_q    <= dec_d;
      bubble_q <= bubble_d;
    end
  end

  assign fp.imem_addr_o  = pc_q;
  assign fp.pc_o         = dec_q.pc;
  assign fp.instr_o      = dec_q.instr;
  assign fp.pred_taken_o = dec_q.pred;
  assign fp.bubble_o     = bubble_q;
endmodule

// File: doc/fetch_predictor.md
# fetch_predictor

Fetch-stage PC generator with a 2-bit bimodal branch predictor. It drives the instruction-memory address and predicts B-type direction from a counter table. JAL is always predicted taken and JALR never taken. Each instruction is handed to decode with its prediction flag, which travels to execute as `branch_taken_i`. It consumes execute's registered resolution (`branch_taken_o`, `branch_pc_o`, `flush_o`) to redirect fetch and train the table.

## Interface
- `PC_INIT`, default `` `PC_INIT ``: reset fetch address.
- `BHT_ENTRIES`, default 64: counter-table depth; power of two, ≥ 4.
- Clock/reset: one clock; reset is synchronous and active-high.
- `clock_i`  in  1  core clock.
- `reset_i`  in  1  synchronous active-high reset.
- `stall_i`  in  1  pipeline stall; holds all state except flush handling.
- `imem_addr_o`  out  XLEN  current fetch PC. The memory read is combinational.
- `instr_i`  in  32  instruction at `imem_addr_o`, valid in the same cycle.
- `pc_o`  out  XLEN  PC of the instruction in the fetch→decode register.
- `instr_o`  out  32  instruction in the fetch→decode register.
- `pred_taken_o`  out  1  prediction for `instr_o`.
- `bubble_o`  out  1  fetch→decode slot is invalid.
- `flush_i`  in  1  execute misprediction or JALR redirect.
- `redirect_pc_i`  in  XLEN  corrected PC, valid with `flush_i`.
- `res_valid_i`  in  1  a B-type instruction resolved in execute this cycle.
- `res_pc_i`  in  XLEN  PC of the resolved branch.
- `res_taken_i`  in  1  actual direction of the resolved branch.

## Operation
- **Pre-decode.** Works on `instr_i[6:0]`:
  - B-type: immB = sext({instr[31], instr[7], instr[30:25], instr[11:8]}) << 1.
  - JAL: immJ = sext({instr[31], instr[19:12], instr[20], instr[30:21]}) << 1.
- **Target convention.** Target = fetch_pc + 4 + imm, identical to execute-stage resolution. This matters because the flush compare in execute is exact.
- **Prediction.**
  - JAL: taken.
  - B-type: taken iff counter[idx] ≥ 2.
  - JALR and all other opcodes: not taken.
- **Table index.** idx = pc[log2(BHT_ENTRIES)+1 : 2]. There is no tag; aliasing is accepted.
- **Counters.** 2-bit saturating: SNT=0, WNT=1, WT=2, ST=3.
  - Reset value: WNT for every entry.
  - Update when `res_valid_i && !stall_i`: increment if `res_taken_i`, else decrement, saturating at 3 and 0.
  - Updates are gated by stall so that held execute registers are not counted more than once.
- **Next PC, in priority order:**
  1. `flush_i`: `redirect_pc_i`.
  2. Predicted taken: target.
  3. Otherwise: fetch_pc + 4.
- **Fetch→decode register.** Loaded on every non-stalled cycle with (fetch_pc, `instr_i`, prediction), and `bubble_o` cleared.
- **On `flush_i`:**
  - `bubble_o` is set to 1, `pred_taken_o` to 0 and `instr_o` to NOP (32'h0000_0013).
  - fetch_pc is set to `redirect_pc_i`.
  - Flush overrides `stall_i`. Repeating a redirect to the same PC is idempotent.
- **Simultaneous flush and table update.** Both happen; the table update is independent of the redirect.
- **Counter read during update.** A read of an entry being updated in the same cycle returns the old value; there is no bypass.
- **Arithmetic.** All PC arithmetic is modulo 2^XLEN, and wrap-around is permitted. The low 2 PC bits are not checked.

## Timing
- **Reset values:**
  - `imem_addr_o` = `pc_o` = `PC_INIT`.
  - `instr_o` = NOP, `pred_taken_o` = 0, `bubble_o` = 1.
  - All counters = WNT.
- **Fetch latency.** The cycle after reset deasserts, `imem_addr_o` = `PC_INIT`. The instruction appears on `instr_o` one cycle later with `bubble_o` = 0.
- **Predicted-taken redirect.** Seen by `imem_addr_o` on the next edge, i.e. a zero-bubble taken branch.
- **Flush.** `imem_addr_o` = `redirect_pc_i` on the edge after `flush_i` is sampled. `bubble_o` is high for exactly that cycle unless the flush repeats.
- **Stall.** `stall_i` without flush freezes fetch_pc, the decode register and the table.
- **Reset mid-operation.** Reset overrides everything on the next edge, including flush and update.

## Structure
- **Shared package** `cpu_core_pkg` gains:
  - `OP_BRANCH` and `OP_JAL` (alongside the existing `OP_JALR`).
  - `bht_cnt_t` enum {SNT, WNT, WT, ST}.
  - `INSTR_NOP`.
- **Sub-module** `bht_2bit`: the counter table, with combinational read port, synchronous update port and synchronous reset to WNT.
- **Top level** `fetch_predictor`: pre-decode, next-PC mux and decode register.

## Test plan
- Reset with `PC_INIT`=0 → `imem_addr_o` sequence 0, 4, 8. `bubble_o` is 1 at reset and 0 from the second cycle.
- JAL at 0x10 with immJ byte offset 0x20 → next `imem_addr_o` = 0x34, and `pred_taken_o` = 1 for that JAL.
- BEQ at 0x10 with immB byte offset 8 after reset → predicted not taken, next `imem_addr_o` = 0x14. Then two `res_valid_i`/`res_taken_i`=1 updates for PC 0x10 → counter = ST; refetching 0x10 gives next address 0x1C.
- `flush_i` with `redirect_pc_i` = 0x200 while `stall_i` = 1 → `imem_addr_o` = 0x200 next cycle, `bubble_o` = 1 and `instr_o` = NOP.
- Saturation: six not-taken updates on one index → counter stays SNT. Four taken updates → ST, and a fifth taken update leaves it at ST.
- `res_valid_i` held for 3 cycles under `stall_i` → counter unchanged. Same-cycle update and read of one index → prediction uses the pre-update value.
